// File: rtl/clk_step_ctrl_if.sv
// Control/status bundle between the clock-enable sequencer and the core/board side.
// The master is the sequencer; the slave drives mode, button and halt.
interface clk_step_ctrl_if;
   logic        run_mode;
   logic        step_btn;
   logic        halt;
   logic        ce_cpu;
   logic        ce_rf;
   logic        step_ack;
   logic [31:0] cycle_cnt;
   logic [1:0]  state;

   modport master (
      input  run_mode, step_btn, halt,
      output ce_cpu, ce_rf, step_ack, cycle_cnt, state
   );

   modport slave (
      output run_mode, step_btn, halt,
      input  ce_cpu, ce_rf, step_ack, cycle_cnt, state
   );
endinterface

// File: rtl/clk_step_ctrl.sv
// Clock-enable sequencer: divides clk into phase-offset ce_rf/ce_cpu pulses with
// free-run, debounced single-step and halt modes.
module clk_step_ctrl #(
   parameter int DIV       = 4,
   parameter int DB_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst,
   clk_step_ctrl_if.master bus
);

   localparam int            CW       = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_RF   = CW'(DIV / 2 - 1);
   localparam logic [15:0]   DB_LAST  = 16'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] div_cnt;
   logic [31:0]   cycle_cnt;
   logic          sync1, sync2, db_level, db_prev;
   logic [15:0]   db_cnt;
   logic          step_req, active, period_end;
   logic          ce_rf, ce_cpu, step_ack;

   // Button path: 2-flop synchronizer, then a level must hold DB_CYCLES cycles.
   // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
         db_cnt   <= '0;
      end else begin
         sync1   <= bus.step_btn;
         sync2   <= sync1;
         db_prev <= db_level;
         if (sync2 == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_level <= sync2;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + 16'd1;
         end
      end
   end

   assign step_req   = db_level & ~db_prev;
   assign active     = (state_q == RUN) || (state_q == STEP);
   assign period_end = (div_cnt == CNT_LAST);

   // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      ce_rf    = 1'b0;
      ce_cpu   = 1'b0;
      step_ack = 1'b0;
      if (active) begin
         ce_rf    = (div_cnt == CNT_RF);
         ce_cpu   = period_end;
         step_ack = (state_q == STEP) && period_end;
      end
      if (bus.halt) begin
         state_d = HALTED;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.run_mode)  state_d = RUN;
               else if (step_req) state_d = STEP;
            end
            RUN:     if (period_end && !bus.run_mode) state_d = IDLE;
            STEP:    if (period_end) state_d = IDLE;
            HALTED:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Divider only advances while a period is live; halt aborts it on the spot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         div_cnt   <= '0;
         cycle_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (bus.halt || !active || period_end) div_cnt <= '0;
         else                                   div_cnt <= div_cnt + 1'b1;
         if (ce_cpu) cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

   assign bus.ce_rf     = ce_rf;
   assign bus.ce_cpu    = ce_cpu;
   assign bus.step_ack  = step_ack;
   assign bus.cycle_cnt = cycle_cnt;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl with DIV=4, DB_CYCLES=16; outputs sampled 1 ns
// after each rising edge, expectations hand-derived per cycle.
module tb_clk_step_ctrl;
   localparam int DIV       = 4;
   localparam int DB_CYCLES = 16;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   clk_step_ctrl_if bus ();

   clk_step_ctrl #(.DIV(DIV), .DB_CYCLES(DB_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic chk_cycle(input string tag, input logic rf, input logic cpu,
                            input logic ack, input logic [1:0] st);
      check({tag, "_ce_rf"},    {31'd0, bus.ce_rf},    {31'd0, rf});
      check({tag, "_ce_cpu"},   {31'd0, bus.ce_cpu},   {31'd0, cpu});
      check({tag, "_step_ack"}, {31'd0, bus.step_ack}, {31'd0, ack});
      check({tag, "_state"},    {30'd0, bus.state},    {30'd0, st});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst          = 1'b0;
      bus.run_mode = 1'b0;
      bus.step_btn = 1'b0;
      bus.halt     = 1'b0;

      // Power-on reset
      #2;
      chk_cycle("por", 1'b0, 1'b0, 1'b0, 2'd0);
      check("por_cycle_cnt", bus.cycle_cnt, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_cycle("idle", 1'b0, 1'b0, 1'b0, 2'd0);

      // Free-run: 40 cycles from RUN entry, ce_rf at cnt 1, ce_cpu at cnt 3
      bus.run_mode = 1'b1;
      tick();
      for (int k = 0; k < 40; k++) begin
         chk_cycle("free", (k % 4 == 1), (k % 4 == 3), 1'b0, 2'd1);
         tick();
      end
      check("free_cycle_cnt", bus.cycle_cnt, 32'd10);

      // Reset mid-RUN at div_cnt=2: outputs clear asynchronously
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk_cycle("rst_async", 1'b0, 1'b0, 1'b0, 2'd0);
      check("rst_async_cycle_cnt", bus.cycle_cnt, 32'd0);
      tick();
      chk_cycle("rst_hold", 1'b0, 1'b0, 1'b0, 2'd0);
      #3;
      rst = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk_cycle("rst_rerun", (k == 1), (k == 3), 1'b0, 2'd1);
         tick();
      end
      check("rst_rerun_cycle_cnt", bus.cycle_cnt, 32'd1);

      // Mode drop at div_cnt=0: period completes, then IDLE with no pulses
      bus.run_mode = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_cycle("drop_period", (k == 1), (k == 3), 1'b0, 2'd1);
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         chk_cycle("drop_idle", 1'b0, 1'b0, 1'b0, 2'd0);
         tick();
      end
      check("drop_cycle_cnt", bus.cycle_cnt, 32'd2);

      // Single step: press 30 cycles; STEP entered on edge 19 after the press
      bus.step_btn = 1'b1;
      for (int n = 1; n <= 60; n++) begin
         tick();
         chk_cycle("step", (n == 20), (n == 22), (n == 22),
                   (n >= 19 && n <= 22) ? 2'd2 : 2'd0);
         if (n == 30) bus.step_btn = 1'b0;
      end
      check("step_cycle_cnt", bus.cycle_cnt, 32'd3);

      // Bounce: toggling every 5 cycles never survives the debounce window
      for (int i = 0; i < 200; i++) begin
         bus.step_btn = ((i / 5) % 2 == 0);
         tick();
         chk_cycle("bounce", 1'b0, 1'b0, 1'b0, 2'd0);
      end
      bus.step_btn = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_cycle("bounce_settle", 1'b0, 1'b0, 1'b0, 2'd0);
      end
      check("bounce_cycle_cnt", bus.cycle_cnt, 32'd3);

      // Halt at div_cnt=1 in RUN for 10 cycles
      bus.run_mode = 1'b1;
      tick();
      chk_cycle("halt_run0", 1'b0, 1'b0, 1'b0, 2'd1);
      tick();
      bus.halt = 1'b1;
      chk_cycle("halt_assert", 1'b1, 1'b0, 1'b0, 2'd1);
      for (int h = 1; h <= 9; h++) begin
         tick();
         chk_cycle("halted", 1'b0, 1'b0, 1'b0, 2'd3);
      end
      check("halted_cycle_cnt", bus.cycle_cnt, 32'd3);
      bus.halt = 1'b0;
      tick();
      chk_cycle("halt_release", 1'b0, 1'b0, 1'b0, 2'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk_cycle("halt_resume", (k == 1), (k == 3), 1'b0, 2'd1);
         tick();
      end
      check("resume_cycle_cnt", bus.cycle_cnt, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Clock-enable sequencer for the RV32IC core, used in place of the free-running clock dividers. It divides the board clock into two phase-offset enable pulses: one for the CPU pipeline register and one for the register file, half a period earlier. It supports free-run, debounced single-step (push-button) and halt modes. It sits between the board clock/button inputs and every enable-gated register in the core.

## Interface
- DIV, 4: CPU period in clk cycles; legal range 2..256.
- DB_CYCLES, 16: consecutive stable cycles required to accept a button level; legal range 2..65535.

- clk  in  1  board clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous and active-low.
- run_mode  in  1  1 = free-run, 0 = single-step; synchronous, sampled every cycle.
- step_btn  in  1  raw asynchronous push-button, active-high, may bounce.
- halt  in  1  synchronous stop request from the core (e.g. ebreak); highest priority.
- ce_cpu  out  1  one-cycle enable for the CPU pipeline register.
- ce_rf  out  1  one-cycle enable for the register file.
- step_ack  out  1  one-cycle pulse that coincides with the ce_cpu closing a single step.
- cycle_cnt  out  32  number of ce_cpu pulses since reset; wraps modulo 2^32.
- state  out  2  IDLE=0, RUN=1, STEP=2, HALTED=3.

## Operation
- Button path:
  - step_btn passes through a 2-flop synchronizer, producing sync.
  - A debounce counter counts the consecutive cycles in which sync differs from db_level. It clears whenever they match.
  - When the count reaches DB_CYCLES, db_level takes the value of sync and the counter clears.
  - step_req = db_level & ~db_prev, where db_prev is db_level delayed one cycle.
- Divider: div_cnt, ceil(log2(DIV)) bits.
  - Increments 0..DIV-1 while state is RUN or STEP, then wraps to 0.
  - Held at 0 in IDLE and HALTED.
- Enable decode, combinational from registered state and div_cnt:
  - ce_rf = (RUN|STEP) & div_cnt==DIV/2-1, using floor division. For DIV=2 this is cnt 0.
  - ce_cpu = (RUN|STEP) & div_cnt==DIV-1.
  - step_ack = STEP & div_cnt==DIV-1.
- cycle_cnt increments by 1 in every cycle where ce_cpu=1.
- FSM transitions, evaluated in this priority order:
  - Any state, halt=1: HALTED on the next edge; div_cnt <- 0.
  - IDLE:
    - run_mode=1 -> RUN.
    - Otherwise, step_req=1 -> STEP.
  - RUN: at div_cnt==DIV-1 with run_mode=0 -> IDLE. The period in progress always completes. No partial periods.
  - STEP:
    - At div_cnt==DIV-1 -> IDLE.
    - step_req while in STEP is dropped, not queued.
    - run_mode changes during STEP are ignored until IDLE is reached.
  - HALTED: halt=0 -> IDLE. Any step_req seen while HALTED is dropped.

## Timing
- Reset (rst=0) takes effect immediately and asynchronously:
  - state=IDLE, div_cnt=0, cycle_cnt=0.
  - Synchronizer flops, db_level and db_prev = 0; debounce counter = 0.
  - All outputs are 0 while rst=0.
- Button held through reset release: it is seen as a fresh rising level and yields exactly one step_req after debounce.
- Step latency (step_btn rising, then stable):
  - sync rises 2 cycles later.
  - db_level rises DB_CYCLES cycles after that.
  - step_req is high in that same cycle.
  - STEP is entered on the next edge.
  - ce_rf follows DIV/2-1 cycles after entry; ce_cpu/step_ack follow DIV-1 cycles after entry.
- RUN entry: the first ce_rf is DIV/2-1 cycles after entering RUN, and the first ce_cpu is DIV-1 cycles after. After that, both pulse every DIV cycles.
- ce_rf and ce_cpu never assert in the same cycle.
- Exactly one ce_rf precedes each ce_cpu within a period, except when halt aborts the period.
- Halt:
  - The cycle in which halt is first high may still carry a decoded pulse.
  - From the next cycle onward, no pulses occur until the FSM re-enters RUN or STEP.
  - An aborted STEP produces no step_ack.
- Simultaneous halt and step_req in IDLE: halt wins; the request is lost.

## Test plan
All scenarios use DIV=4, DB_CYCLES=16.
- Reset mid-RUN: drive rst=0 at div_cnt=2 -> ce_cpu, ce_rf, step_ack and cycle_cnt are 0 immediately, state=0. After release with run_mode=1, the first ce_cpu occurs 4 cycles after RUN entry.
- Free-run: run_mode=1 for 40 cycles after RUN entry -> ce_cpu at cnt 3 every 4 cycles (10 pulses), ce_rf at cnt 1 (2 cycles before each), cycle_cnt=10.
- Single step: run_mode=0, step_btn high for 30 cycles, then low -> step_req in cycle 18 after the press, STEP entered, exactly one ce_rf, one ce_cpu and one step_ack, cycle_cnt +1, back in IDLE. Releasing the button produces no further step.
- Bounce rejection: step_btn toggling every 5 cycles for 200 cycles -> db_level stays 0, no step_req, state stays IDLE.
- Halt: assert halt for 10 cycles at div_cnt=1 in RUN -> at most the one decoded pulse in the assert cycle, then none, state=3. Release with run_mode=1 -> IDLE then RUN, and ce_cpu resumes 4 cycles after RUN entry.
- Mode drop: clear run_mode at div_cnt=0 in RUN -> the period finishes with ce_rf and ce_cpu, the FSM then goes to IDLE, and no further pulses occur.
